// File: rtl/alarm_ctrl.sv
// Alarm controller downstream of dclock: stores an hh:mm alarm and drives a buzzer FSM (disarmed/armed/ringing/snoozing).
// Optional build macro ALARM_BEEP_EN: buzzer beeps on even seconds instead of a continuous tone.
module alarm_ctrl #(
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] hrs,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  input  logic       set_en,
  input  logic [6:0] set_hrs,
  input  logic [6:0] set_min,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic [6:0] alarm_hrs,
  output logic [6:0] alarm_min,
  output logic       armed,
  output logic       ringing,
  output logic       buzz,
  output logic       set_err,
  output logic [2:0] snooze_left
);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_RINGING  = 2'd2,
    S_SNOOZE   = 2'd3
  } state_t;

  localparam logic [11:0] RING_LAST = 12'(RING_SECS - 1);
  localparam logic [11:0] SNZ_LAST  = 12'(SNOOZE_SECS - 1);
  localparam logic [2:0]  SNZ_MAX   = 3'(MAX_SNOOZE);

  state_t      r_state, w_next;
  logic [6:0]  r_sec_q, r_alarm_hrs, r_alarm_min;
  logic [11:0] r_ring_cnt, r_snz_cnt, w_ring_cnt_nx, w_snz_cnt_nx;
  logic [2:0]  r_snooze_left, w_snooze_left_nx;
  logic        r_armed, r_ringing, r_buzz, r_set_err;
  logic        w_tick, w_match, w_set_ok_state, w_set_valid, w_load, w_set_err_nx, w_buzz_nx;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // A clock held at 00:00:00 out of reset never ticks, so a 00:00 alarm cannot fire spuriously.
  assign w_tick  = (sec != r_sec_q);
  assign w_match = w_tick && (sec == 7'd0) && (hrs == r_alarm_hrs) && (min == r_alarm_min);

  assign w_set_ok_state = (r_state == S_DISARMED) || (r_state == S_ARMED);
  assign w_set_valid    = (set_hrs <= 7'd23) && (set_min <= 7'd59);
  assign w_load         = set_en && w_set_ok_state && w_set_valid;
  assign w_set_err_nx   = set_en && w_set_ok_state && !w_set_valid;

  always_comb begin
    w_next           = r_state;
    w_ring_cnt_nx    = r_ring_cnt;
    w_snz_cnt_nx     = r_snz_cnt;
    w_snooze_left_nx = r_snooze_left;
    case (r_state)
      S_DISARMED: begin
        if (arm) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (!arm) begin
          w_next = S_DISARMED;
        end else if (w_match) begin
          w_next           = S_RINGING;
          w_ring_cnt_nx    = 12'd0;
          w_snooze_left_nx = SNZ_MAX;
        end
      end
      S_RINGING: begin
        if (!arm) begin
          w_next = S_DISARMED;
        end else if (stop) begin
          w_next = S_ARMED;
        end else if (snooze) begin
          // With no snoozes left the request behaves exactly like stop.
          if (r_snooze_left != 3'd0) begin
            w_next           = S_SNOOZE;
            w_snz_cnt_nx     = 12'd0;
            w_snooze_left_nx = r_snooze_left - 3'd1;
          end else begin
            w_next = S_ARMED;
          end
        end else if (w_tick) begin
          if (r_ring_cnt == RING_LAST) w_next = S_ARMED;
          else                         w_ring_cnt_nx = sat_inc(r_ring_cnt);
        end
      end
      S_SNOOZE: begin
        if (!arm) begin
          w_next = S_DISARMED;
        end else if (stop) begin
          w_next = S_ARMED;
        end else if (w_tick) begin
          if (r_snz_cnt == SNZ_LAST) begin
            w_next        = S_RINGING;
            w_ring_cnt_nx = 12'd0;
          end else begin
            w_snz_cnt_nx = sat_inc(r_snz_cnt);
          end
        end
      end
      default: w_next = S_DISARMED;
    endcase
  end

`ifdef ALARM_BEEP_EN
  assign w_buzz_nx = (w_next == S_RINGING) && !sec[0];
`else
  assign w_buzz_nx = (w_next == S_RINGING);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_DISARMED;
      r_sec_q       <= 7'd0;
      r_alarm_hrs   <= 7'd0;
      r_alarm_min   <= 7'd0;
      r_ring_cnt    <= 12'd0;
      r_snz_cnt     <= 12'd0;
      r_snooze_left <= SNZ_MAX;
      r_armed       <= 1'b0;
      r_ringing     <= 1'b0;
      r_buzz        <= 1'b0;
      r_set_err     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_sec_q       <= sec;
      r_ring_cnt    <= w_ring_cnt_nx;
      r_snz_cnt     <= w_snz_cnt_nx;
      r_snooze_left <= w_snooze_left_nx;
      r_armed       <= (w_next != S_DISARMED);
      r_ringing     <= (w_next == S_RINGING);
      r_buzz        <= w_buzz_nx;
      r_set_err     <= w_set_err_nx;
      if (w_load) begin
        r_alarm_hrs <= set_hrs;
        r_alarm_min <= set_min;
      end
    end
  end

  assign alarm_hrs   = r_alarm_hrs;
  assign alarm_min   = r_alarm_min;
  assign armed       = r_armed;
  assign ringing     = r_ringing;
  assign buzz        = r_buzz;
  assign set_err     = r_set_err;
  assign snooze_left = r_snooze_left;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with default parameters (RING_SECS=30, SNOOZE_SECS=300, MAX_SNOOZE=3).
module tb_alarm_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] hrs = 7'd0, min = 7'd0, sec = 7'd0;
  logic       set_en = 1'b0;
  logic [6:0] set_hrs = 7'd0, set_min = 7'd0;
  logic       arm = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic [6:0] alarm_hrs, alarm_min;
  logic       armed, ringing, buzz, set_err;
  logic [2:0] snooze_left;

  int n_vec = 0;
  int n_bad = 0;
  int th = 0, tm = 0, ts = 0;

  alarm_ctrl dut (
    .clk(clk), .rst(rst), .hrs(hrs), .min(min), .sec(sec),
    .set_en(set_en), .set_hrs(set_hrs), .set_min(set_min),
    .arm(arm), .snooze(snooze), .stop(stop),
    .alarm_hrs(alarm_hrs), .alarm_min(alarm_min),
    .armed(armed), .ringing(ringing), .buzz(buzz),
    .set_err(set_err), .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_t(input int h, input int m, input int s);
    th = h; tm = m; ts = s;
    hrs = 7'(h); min = 7'(m); sec = 7'(s);
  endtask

  // Each simulated second lasts two clocks.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      ts++;
      if (ts == 60) begin ts = 0; tm++; end
      if (tm == 60) begin tm = 0; th++; end
      if (th == 24) th = 0;
      set_t(th, tm, ts);
      cyc(2);
    end
  endtask

  function automatic logic exp_buzz(input logic ring, input logic [6:0] s);
`ifdef ALARM_BEEP_EN
    return ring & ~s[0];
`else
    return ring;
`endif
  endfunction

  task automatic ring_up();
    set_t(7, 29, 59);
    cyc(2);
    set_t(7, 30, 0);
    cyc(2);
  endtask

  initial begin
    // Asynchronous reset assertion, checked between clock edges
    #2 rst = 1'b1;
    #1;
    chk("rst_armed", 12'(armed), 12'd0);
    chk("rst_ringing", 12'(ringing), 12'd0);
    chk("rst_buzz", 12'(buzz), 12'd0);
    chk("rst_set_err", 12'(set_err), 12'd0);
    chk("rst_snz_left", 12'(snooze_left), 12'd3);
    chk("rst_alarm_hrs", 12'(alarm_hrs), 12'd0);
    chk("rst_alarm_min", 12'(alarm_min), 12'd0);
    cyc(2);
    rst = 1'b0;

    // 00:00 alarm must not fire while the clock sits at 00:00:00
    arm = 1'b1;
    cyc(3);
    chk("zero_armed", 12'(armed), 12'd1);
    chk("zero_no_ring", 12'(ringing), 12'd0);

    // Valid load
    set_hrs = 7'd7; set_min = 7'd30; set_en = 1'b1;
    cyc(1);
    set_en = 1'b0;
    chk("load_hrs", 12'(alarm_hrs), 12'd7);
    chk("load_min", 12'(alarm_min), 12'd30);
    chk("load_no_err", 12'(set_err), 12'd0);

    // Invalid hour, then invalid minute
    set_hrs = 7'd24; set_min = 7'd10; set_en = 1'b1;
    cyc(1);
    set_en = 1'b0;
    chk("bad_hr_err", 12'(set_err), 12'd1);
    chk("bad_hr_keep_h", 12'(alarm_hrs), 12'd7);
    chk("bad_hr_keep_m", 12'(alarm_min), 12'd30);
    cyc(1);
    chk("err_one_cycle", 12'(set_err), 12'd0);
    set_hrs = 7'd5; set_min = 7'd60; set_en = 1'b1;
    cyc(1);
    set_en = 1'b0;
    chk("bad_min_err", 12'(set_err), 12'd1);
    chk("bad_min_keep_h", 12'(alarm_hrs), 12'd7);

    // Alarm fires one clock after 07:30:00 first appears
    set_t(7, 29, 59);
    cyc(2);
    chk("pre_ring", 12'(ringing), 12'd0);
    set_t(7, 30, 0);
    cyc(1);
    chk("ring_rise", 12'(ringing), 12'd1);
    chk("ring_buzz", 12'(buzz), 12'd1);
    cyc(1);
    adv(1);
    chk("buzz_sec1", 12'(buzz), 12'(exp_buzz(1'b1, sec)));
    adv(28);
    chk("ring_at_29", 12'(ringing), 12'd1);
    adv(1);
    chk("timeout_ring", 12'(ringing), 12'd0);
    chk("timeout_armed", 12'(armed), 12'd1);
    chk("timeout_buzz", 12'(buzz), 12'd0);

    // Snooze three times, fourth snooze acts as stop
    ring_up();
    chk("snz_ring", 12'(ringing), 12'd1);
    chk("snz_left_init", 12'(snooze_left), 12'd3);
    for (int k = 0; k < 3; k++) begin
      snooze = 1'b1;
      cyc(1);
      snooze = 1'b0;
      chk("snz_drop", 12'(ringing), 12'd0);
      chk("snz_left", 12'(snooze_left), 12'(2 - k));
      adv(299);
      chk("snz_early", 12'(ringing), 12'd0);
      adv(1);
      chk("snz_rering", 12'(ringing), 12'd1);
      chk("snz_rering_min", 12'(min), 12'(35 + 5 * k));
    end
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    chk("snz4_ring", 12'(ringing), 12'd0);
    chk("snz4_armed", 12'(armed), 12'd1);
    chk("snz4_left", 12'(snooze_left), 12'd0);
    adv(300);
    chk("snz4_no_rering", 12'(ringing), 12'd0);

    // set_en ignored while ringing; stop+snooze together acts as stop
    ring_up();
    chk("re_ring", 12'(ringing), 12'd1);
    chk("re_left", 12'(snooze_left), 12'd3);
    set_hrs = 7'd8; set_min = 7'd0; set_en = 1'b1;
    cyc(1);
    set_hrs = 7'd30;
    cyc(1);
    set_en = 1'b0;
    chk("ring_set_ign", 12'(alarm_hrs), 12'd7);
    chk("ring_set_noerr", 12'(set_err), 12'd0);
    stop = 1'b1; snooze = 1'b1;
    cyc(1);
    stop = 1'b0; snooze = 1'b0;
    chk("stopsnz_ring", 12'(ringing), 12'd0);
    chk("stopsnz_armed", 12'(armed), 12'd1);
    chk("stopsnz_left", 12'(snooze_left), 12'd3);

    // Disarm while ringing
    ring_up();
    arm = 1'b0;
    cyc(1);
    chk("disarm_armed", 12'(armed), 12'd0);
    chk("disarm_ring", 12'(ringing), 12'd0);
    arm = 1'b1;
    cyc(1);

    // Asynchronous reset in the middle of a snooze
    ring_up();
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    chk("mid_snz_left", 12'(snooze_left), 12'd2);
    #1 rst = 1'b1;
    #1;
    chk("arst_armed", 12'(armed), 12'd0);
    chk("arst_ring", 12'(ringing), 12'd0);
    chk("arst_buzz", 12'(buzz), 12'd0);
    chk("arst_left", 12'(snooze_left), 12'd3);
    chk("arst_hrs", 12'(alarm_hrs), 12'd0);
    chk("arst_min", 12'(alarm_min), 12'd0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk("post_rst_armed", 12'(armed), 12'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
